// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit_if
// Description : Control inputs and fetch outputs of the fetch PC stage,
//               bundled so the stage and its environment share one port.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_unit_if;
    // Control from the pipeline / sequencer
    logic        start;
    logic        haltRequest;
    logic        stall;
    logic        redirectValid;
    logic [31:0] redirectTarget;

    // Towards instruction memory and decode
    logic [31:0] instructionAddress;
    logic [31:0] fetchPc;
    logic        fetchValid;
    logic [31:0] fetchCount;
    logic        running;

    // Environment side: drives control, observes fetch results
    modport master (
        output start, haltRequest, stall, redirectValid, redirectTarget,
        input  instructionAddress, fetchPc, fetchValid, fetchCount, running
    );

    // Fetch stage side
    modport slave (
        input  start, haltRequest, stall, redirectValid, redirectTarget,
        output instructionAddress, fetchPc, fetchValid, fetchCount, running
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Program counter and fetch control in front of a word-addressed
//               synchronous instruction memory (1-cycle registered read).
//               Tracks which address produced the instruction on the memory
//               output, and handles start/halt, decode stalls and redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd1
) (
    input  wire logic         clock,
    input  wire logic         reset,
    fetch_pc_unit_if.slave    bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_HALT = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_pc;
    logic        r_fetch_valid;
    logic [31:0] r_fetch_count;
    logic        w_hold;
    logic        w_fetch;

    // Re-read the presented address while decode is stalled on a valid
    // instruction, so the memory output stays put; a redirect breaks the hold.
    always_comb begin
        w_hold = bus.stall && r_fetch_valid && (r_state == c_RUN)
                 && !bus.redirectValid;
    end

    // Advance the PC only in RUN with no pending halt (halt takes effect at
    // this edge) and no active hold.
    always_comb begin
        w_fetch = (r_state == c_RUN) && !bus.haltRequest && !w_hold;
    end

    // Next-state logic: halt wins in RUN, start wins in IDLE/HALT.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.start)       w_state_next = c_RUN;
            c_RUN:   if (bus.haltRequest) w_state_next = c_HALT;
            c_HALT:  if (bus.start)       w_state_next = c_RUN;
            default:                      w_state_next = c_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC, presented-address tracking and squash; redirect has top priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_fetch_pc    <= 32'd0;
            r_fetch_valid <= 1'b0;
        end else if (bus.redirectValid) begin
            r_pc          <= bus.redirectTarget;
            r_fetch_valid <= 1'b0;
        end else if (w_fetch) begin
            r_fetch_pc    <= r_pc;
            r_fetch_valid <= 1'b1;
            r_pc          <= r_pc + PC_STEP;
        end else if (!w_hold) begin
            // Halting or idle: nothing new is fetched, PC keeps the next
            // unfetched address.
            r_fetch_valid <= 1'b0;
        end
    end

    // Count instructions actually accepted by decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_count <= 32'd0;
        end else if (r_fetch_valid && !bus.stall && !bus.redirectValid) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign bus.instructionAddress = w_hold ? r_fetch_pc : r_pc;
    assign bus.fetchPc            = r_fetch_pc;
    assign bus.fetchValid         = r_fetch_valid;
    assign bus.fetchCount         = r_fetch_count;
    assign bus.running            = (r_state == c_RUN);

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_unit
// Description : Directed self-checking bench for fetch_pc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_unit;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(
        .RESET_PC (32'd0),
        .PC_STEP  (32'd1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Check all fetch outputs at once.
    task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] pc,
                           input logic valid, input logic [31:0] cnt, input logic run);
        chk({tag, ".addr"},  bus.instructionAddress, addr);
        chk({tag, ".pc"},    bus.fetchPc, pc);
        chk({tag, ".valid"}, {31'd0, bus.fetchValid}, {31'd0, valid});
        chk({tag, ".count"}, bus.fetchCount, cnt);
        chk({tag, ".run"},   {31'd0, bus.running}, {31'd0, run});
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.haltRequest = 1'b0;
        bus.stall = 1'b0;
        bus.redirectValid = 1'b0;
        bus.redirectTarget = 32'd0;

        // 1. reset, then start
        tick(); tick();
        chk_all("reset", 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        reset = 1'b0; bus.start = 1'b1;
        tick(); bus.start = 1'b0; #1;
        chk_all("run0", 32'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        tick(); chk_all("f0", 32'd1, 32'd0, 1'b1, 32'd0, 1'b1);
        tick(); chk_all("f1", 32'd2, 32'd1, 1'b1, 32'd1, 1'b1);
        tick(); chk_all("f2", 32'd3, 32'd2, 1'b1, 32'd2, 1'b1);
        tick(); chk_all("f3", 32'd4, 32'd3, 1'b1, 32'd3, 1'b1);
        tick(); tick(); chk_all("f5", 32'd6, 32'd5, 1'b1, 32'd5, 1'b1);

        // 2. stall three cycles on word 5
        bus.stall = 1'b1; #1;
        chk("stall.addr", bus.instructionAddress, 32'd5);
        for (int i = 0; i < 3; i++) begin
            tick(); chk_all("stall", 32'd5, 32'd5, 1'b1, 32'd5, 1'b1);
        end
        bus.stall = 1'b0; #1;
        chk("release.addr", bus.instructionAddress, 32'd6);
        tick(); chk_all("f6", 32'd7, 32'd6, 1'b1, 32'd6, 1'b1);
        tick(); chk_all("f7", 32'd8, 32'd7, 1'b1, 32'd7, 1'b1);

        // 3. redirect to 0x40, word 7 squashed
        bus.redirectValid = 1'b1; bus.redirectTarget = 32'h40; #1;
        chk("redir.addr", bus.instructionAddress, 32'd8);
        tick(); bus.redirectValid = 1'b0; #1;
        chk_all("bubble", 32'h40, 32'd7, 1'b0, 32'd7, 1'b1);
        tick(); chk_all("f40", 32'h41, 32'h40, 1'b1, 32'd7, 1'b1);
        tick(); chk_all("f41", 32'h42, 32'h41, 1'b1, 32'd8, 1'b1);

        // 4. redirect together with stall: redirect wins
        bus.stall = 1'b1; bus.redirectValid = 1'b1; bus.redirectTarget = 32'h80; #1;
        chk("rs.addr", bus.instructionAddress, 32'h42);
        tick(); bus.redirectValid = 1'b0; #1;
        chk_all("rs.bubble", 32'h80, 32'h41, 1'b0, 32'd8, 1'b1);
        tick(); chk_all("rs.f80", 32'h80, 32'h80, 1'b1, 32'd8, 1'b1);
        bus.stall = 1'b0;

        // 5. halt at fetchPc=10, pc=11
        bus.redirectValid = 1'b1; bus.redirectTarget = 32'd10;
        tick(); bus.redirectValid = 1'b0; #1;
        chk_all("r10", 32'd10, 32'h80, 1'b0, 32'd8, 1'b1);
        tick(); chk_all("f10", 32'd11, 32'd10, 1'b1, 32'd8, 1'b1);
        bus.haltRequest = 1'b1;
        tick(); bus.haltRequest = 1'b0; #1;
        chk_all("halt", 32'd11, 32'd10, 1'b0, 32'd9, 1'b0);
        tick(); chk_all("halt2", 32'd11, 32'd10, 1'b0, 32'd9, 1'b0);
        bus.start = 1'b1;
        tick(); bus.start = 1'b0; #1;
        chk_all("resume", 32'd11, 32'd10, 1'b0, 32'd9, 1'b1);
        tick(); chk_all("f11", 32'd12, 32'd11, 1'b1, 32'd9, 1'b1);
        // start+halt in RUN: halt wins; in HALT: start wins
        bus.start = 1'b1; bus.haltRequest = 1'b1;
        tick(); chk_all("sh.run", 32'd12, 32'd11, 1'b0, 32'd10, 1'b0);
        tick(); chk_all("sh.halt", 32'd12, 32'd11, 1'b0, 32'd10, 1'b1);
        bus.start = 1'b0; bus.haltRequest = 1'b0;
        tick(); chk_all("f12", 32'd13, 32'd12, 1'b1, 32'd10, 1'b1);

        // 6. reset mid-run during stall, then wrap at 1023/1024 and 2^32
        bus.stall = 1'b1; reset = 1'b1;
        tick(); chk_all("mreset", 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        reset = 1'b0; bus.stall = 1'b0;
        bus.redirectValid = 1'b1; bus.redirectTarget = 32'd1023;
        tick(); bus.redirectValid = 1'b0; #1;
        chk_all("idle.r", 32'd1023, 32'd0, 1'b0, 32'd0, 1'b0);
        bus.start = 1'b1;
        tick(); bus.start = 1'b0; #1;
        chk_all("run1023", 32'd1023, 32'd0, 1'b0, 32'd0, 1'b1);
        tick(); chk_all("f1023", 32'd1024, 32'd1023, 1'b1, 32'd0, 1'b1);
        tick(); chk_all("f1024", 32'd1025, 32'd1024, 1'b1, 32'd1, 1'b1);
        bus.redirectValid = 1'b1; bus.redirectTarget = 32'hFFFF_FFFF;
        tick(); bus.redirectValid = 1'b0; #1;
        chk_all("rmax", 32'hFFFF_FFFF, 32'd1024, 1'b0, 32'd1, 1'b1);
        tick(); chk_all("wrap", 32'd0, 32'hFFFF_FFFF, 1'b1, 32'd1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
